isa_bus_sequencer: RTL
======================

ISA_BUS_SEQUENCER -- requirements
Module: isa_bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_SETUP_CYCLES, default 1, address_load_n low time in clocks (range 1..255).
REQ-002 SHALL have parameter WRITE_STROBE_CYCLES, default 5, nominal iow_n low time (range 1..255).
REQ-003 SHALL have parameter READ_STROBE_CYCLES, default 5, nominal ior_n low time (range 1..255).
REQ-004 SHALL have parameter RECOVERY_CYCLES, default 0, idle gap after strobe release (range 0..255).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, max IOCHRDY wait-state clocks (range 1..1023).
REQ-006 SHALL have port clock  input  1  bus sequencer clock (8 MHz nominal).
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports cmd_read / cmd_write  input  1 each  level requests from the control register.
REQ-009 SHALL have port iochrdy  input  1  ISA channel ready, high = ready.
REQ-010 SHALL have ports address_load_n, data_load_n, iow_n, ior_n, control_reset_n  output  1 each  active-low strobes.
REQ-011 SHALL have ports busy, timeout  output  1 each  active-high status.

Function
REQ-012 States SHALL be IDLE, ADDR, DLOAD, STROBE, RECOVER, DONE; all outputs registered, decoded from state.
REQ-013 IDLE: all active-low outputs high, busy=0; cmd sampled only here; cmd_read wins if both high; next ADDR.
REQ-014 ADDR: address_load_n=0 for ADDR_SETUP_CYCLES clocks; then DLOAD for write, STROBE for read.
REQ-015 DLOAD: data_load_n=0 for exactly 1 clock; next STROBE.
REQ-016 STROBE: iow_n=0 (write) or ior_n=0 (read) for the strobe count of that direction.
REQ-017 Read: data_load_n SHALL be 0 only during the final STROBE clock (data capture).
REQ-018 After STROBE: RECOVER for RECOVERY_CYCLES clocks with all strobes high; RECOVERY_CYCLES=0 skips RECOVER.
REQ-019 DONE: control_reset_n=0 for exactly 1 clock; next IDLE; cmd ignored in DONE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Phase counter SHALL be 8 bits, loaded on state entry, no wrap; timeout counter 10 bits, saturating.
REQ-022 Cmd changes outside IDLE SHALL have no effect on the running cycle.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE, all active-low outputs 1, busy=0, timeout=0, counters 0, regardless of state.
REQ-024 Reset mid-strobe SHALL release the strobe at that same edge; no DONE pulse is generated.

Configuration
REQ-025 Macro ISA_SEQ_IOCHRDY_EN defined: when the STROBE counter reaches its final clock and iochrdy=0, STROBE SHALL hold (strobe stays low, read data_load_n withheld) until iochrdy=1, then perform the final clock.
REQ-026 With ISA_SEQ_IOCHRDY_EN, if wait clocks reach TIMEOUT_CYCLES, the strobe SHALL release, timeout SHALL pulse 1 for 1 clock, read data_load_n SHALL NOT assert, and flow continues to RECOVER/DONE.
REQ-027 Macro undefined: iochrdy ignored, strobe length fixed, timeout tied 0.

Verification
REQ-028 Defaults, cmd_write=1 sampled at edge 0 -> address_load_n=0 cycle 1, data_load_n=0 cycle 2, iow_n=0 cycles 3-7, control_reset_n=0 cycle 8, IDLE cycle 9.
REQ-029 Defaults, cmd_read=1 at edge 0 -> address_load_n=0 cycle 1, ior_n=0 cycles 2-6, data_load_n=0 cycle 6 only, control_reset_n=0 cycle 7.
REQ-030 cmd_read=cmd_write=1 together -> read sequence only, iow_n never low.
REQ-031 IOCHRDY_EN, read, iochrdy=0 for 3 clocks from final strobe clock -> ior_n low 8 clocks, data_load_n low once after iochrdy rises.
REQ-032 IOCHRDY_EN, TIMEOUT_CYCLES=4, iochrdy held 0 -> timeout=1 for 1 clock, no data_load_n, control_reset_n pulse, busy=0 after.
REQ-033 reset=0 during write cycle 5 (iow_n low) -> next edge all outputs inactive, busy=0, no control_reset_n pulse; RECOVERY_CYCLES=3 run shows 3 all-high clocks before DONE.

Source files
------------

// File: rtl/isa_bus_sequencer_if.sv
// Handshake and ISA strobe bundle for isa_bus_sequencer.
// master = sequencer side, slave = control register / bus model side.
interface isa_bus_sequencer_if;
  logic cmd_read;
  logic cmd_write;
  logic iochrdy;
  logic address_load_n;
  logic data_load_n;
  logic iow_n;
  logic ior_n;
  logic control_reset_n;
  logic busy;
  logic timeout;

  modport master (
    input  cmd_read, cmd_write, iochrdy,
    output address_load_n, data_load_n, iow_n, ior_n, control_reset_n, busy, timeout
  );

  modport slave (
    output cmd_read, cmd_write, iochrdy,
    input  address_load_n, data_load_n, iow_n, ior_n, control_reset_n, busy, timeout
  );
endinterface

// File: rtl/isa_bus_sequencer.sv
// ISA I/O cycle sequencer: address load, data load, read/write strobe, recovery, control reset.
// Optional IOCHRDY wait-state support with timeout: define ISA_SEQ_IOCHRDY_EN.
//
// state     | meaning
// S_IDLE    | waiting for cmd_read / cmd_write, all strobes inactive
// S_ADDR    | address_load_n low for ADDR_SETUP_CYCLES
// S_DLOAD   | write only: data_load_n low for one clock
// S_STROBE  | iow_n / ior_n low; read captures data on the final clock
// S_RECOVER | all strobes high for RECOVERY_CYCLES (skipped when 0)
// S_DONE    | control_reset_n low for one clock
module isa_bus_sequencer #(
  parameter int ADDR_SETUP_CYCLES   = 1,
  parameter int WRITE_STROBE_CYCLES = 5,
  parameter int READ_STROBE_CYCLES  = 5,
  parameter int RECOVERY_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  isa_bus_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DLOAD, S_STROBE, S_RECOVER, S_DONE
  } state_t;

  localparam logic [7:0] ADDR_LD = 8'(ADDR_SETUP_CYCLES - 1);
  localparam logic [7:0] WR_LD   = 8'(WRITE_STROBE_CYCLES - 1);
  localparam logic [7:0] RD_LD   = 8'(READ_STROBE_CYCLES - 1);
  localparam logic [7:0] REC_LD  = (RECOVERY_CYCLES > 0) ? 8'(RECOVERY_CYCLES - 1) : 8'd0;
  localparam state_t     POST_STROBE = (RECOVERY_CYCLES > 0) ? S_RECOVER : S_DONE;
  localparam logic [5:0] OUTS_IDLE   = 6'b111110;

  state_t      r_state;
  logic        r_dir;     // 1 = read
  logic        r_final;   // current STROBE clock is the last one
  logic [7:0]  r_cnt;
  logic [5:0]  r_outs;    // {address_load_n, data_load_n, iow_n, ior_n, control_reset_n, busy}
  logic [7:0]  w_len_ld;
  logic        w_rdy;

  assign w_len_ld = r_dir ? RD_LD : WR_LD;

`ifdef ISA_SEQ_IOCHRDY_EN
  localparam logic [9:0] TMO_LIM = 10'(TIMEOUT_CYCLES);
  logic        r_wait;
  logic        r_timeout;
  logic [9:0]  r_tmo;
  assign w_rdy       = bus.iochrdy;
  assign bus.timeout = r_timeout;
`else
  assign w_rdy       = 1'b1;
  assign bus.timeout = 1'b0;
`endif

  assign {bus.address_load_n, bus.data_load_n, bus.iow_n, bus.ior_n,
          bus.control_reset_n, bus.busy} = r_outs;

  // Output pattern for the state being entered; cap asserts the read data capture.
  function automatic logic [5:0] f_outs(input state_t s, input logic rd, input logic cap);
    logic [5:0] o;
    o = OUTS_IDLE;
    case (s)
      S_IDLE:    o = OUTS_IDLE;
      S_ADDR:    o = 6'b011111;
      S_DLOAD:   o = 6'b101111;
      S_STROBE:  o = {1'b1, ~(rd & cap), rd, ~rd, 1'b1, 1'b1};
      S_RECOVER: o = 6'b111111;
      S_DONE:    o = 6'b111101;
      default:   o = OUTS_IDLE;
    endcase
    return o;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_final   <= 1'b0;
      r_cnt     <= 8'd0;
      r_outs    <= OUTS_IDLE;
`ifdef ISA_SEQ_IOCHRDY_EN
      r_wait    <= 1'b0;
      r_timeout <= 1'b0;
      r_tmo     <= 10'd0;
`endif
    end else begin
`ifdef ISA_SEQ_IOCHRDY_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_read || bus.cmd_write) begin
            r_dir   <= bus.cmd_read;
            r_state <= S_ADDR;
            r_cnt   <= ADDR_LD;
            r_outs  <= f_outs(S_ADDR, bus.cmd_read, 1'b0);
          end
        end

        S_ADDR: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!r_dir) begin
            r_state <= S_DLOAD;
            r_outs  <= f_outs(S_DLOAD, 1'b0, 1'b0);
          end else begin
            r_state <= S_STROBE;
            r_cnt   <= w_len_ld;
            if (w_len_ld == 8'd0) begin
              r_final <= w_rdy;
`ifdef ISA_SEQ_IOCHRDY_EN
              r_wait  <= ~w_rdy;
              r_tmo   <= 10'd1;
`endif
              r_outs  <= f_outs(S_STROBE, r_dir, w_rdy);
            end else begin
              r_final <= 1'b0;
              r_outs  <= f_outs(S_STROBE, r_dir, 1'b0);
            end
          end
        end

        S_DLOAD: begin
          r_state <= S_STROBE;
          r_cnt   <= w_len_ld;
          if (w_len_ld == 8'd0) begin
            r_final <= w_rdy;
`ifdef ISA_SEQ_IOCHRDY_EN
            r_wait  <= ~w_rdy;
            r_tmo   <= 10'd1;
`endif
          end else begin
            r_final <= 1'b0;
          end
          r_outs  <= f_outs(S_STROBE, 1'b0, 1'b0);
        end

        S_STROBE: begin
`ifdef ISA_SEQ_IOCHRDY_EN
          // Wait states sit in front of the final clock so capture follows iochrdy.
          if (r_wait) begin
            if (bus.iochrdy) begin
              r_wait  <= 1'b0;
              r_tmo   <= 10'd0;
              r_final <= 1'b1;
              r_outs  <= f_outs(S_STROBE, r_dir, 1'b1);
            end else if (r_tmo >= TMO_LIM) begin
              r_wait    <= 1'b0;
              r_tmo     <= 10'd0;
              r_timeout <= 1'b1;
              r_state   <= POST_STROBE;
              r_cnt     <= REC_LD;
              r_outs    <= f_outs(POST_STROBE, r_dir, 1'b0);
            end else if (r_tmo != 10'h3FF) begin
              r_tmo <= r_tmo + 10'd1;
            end
          end else
`endif
          if (r_final) begin
            r_final <= 1'b0;
            r_state <= POST_STROBE;
            r_cnt   <= REC_LD;
            r_outs  <= f_outs(POST_STROBE, r_dir, 1'b0);
          end else if (r_cnt > 8'd1) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_cnt   <= 8'd0;
            r_final <= w_rdy;
`ifdef ISA_SEQ_IOCHRDY_EN
            r_wait  <= ~w_rdy;
            r_tmo   <= 10'd1;
`endif
            r_outs  <= f_outs(S_STROBE, r_dir, w_rdy);
          end
        end

        S_RECOVER: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state <= S_DONE;
            r_outs  <= f_outs(S_DONE, r_dir, 1'b0);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_outs  <= OUTS_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_outs  <= OUTS_IDLE;
        end
      endcase
    end
  end

endmodule
